// File: rtl/rst_seq_sync_if.sv
// rst_seq_sync_if: software reset request and sequenced reset outputs of one clock domain; RST_CAUSE exists only with RST_CAUSE_EN
interface rst_seq_sync_if #(
    parameter int NUM_CH = 4
);
    logic              SW_RST;
    logic [NUM_CH-1:0] SYNC_RST;
    logic              RST_DONE;
`ifdef RST_CAUSE_EN
    logic [1:0]        RST_CAUSE;
    modport master (input SW_RST, output SYNC_RST, output RST_DONE, output RST_CAUSE);
    modport slave  (output SW_RST, input SYNC_RST, input RST_DONE, input RST_CAUSE);
`else
    modport master (input SW_RST, output SYNC_RST, output RST_DONE);
    modport slave  (output SW_RST, input SYNC_RST, input RST_DONE);
`endif
endinterface

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: async-assert, synchronized and sequenced-release reset generator; RST_CAUSE_EN adds the RST_CAUSE output
module rst_seq_sync #(
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 4,
    parameter int STRETCH    = 16,
    parameter int REL_DLY    = 8
) (
    input  logic           CLK,
    input  logic           RST,
    rst_seq_sync_if.master bus
);
    localparam int CW = $clog2(STRETCH > REL_DLY ? STRETCH : REL_DLY) + 1;
    localparam int IW = $clog2(NUM_CH + 1);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("rst_seq_sync: NUM_STAGES must be >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("rst_seq_sync: NUM_CH must be >= 1");
    end
    if (STRETCH < 1) begin : g_bad_stretch
        $error("rst_seq_sync: STRETCH must be >= 1");
    end
    if (REL_DLY < 1) begin : g_bad_rel
        $error("rst_seq_sync: REL_DLY must be >= 1");
    end

    typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_RELEASE, S_DONE} state_t;

    logic [NUM_STAGES-1:0] sync_q;
    logic                  sq;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_CH-1:0]     rel_q, rel_d;
    logic                  done_q, done_d;
    logic                  sw_acc;
    logic                  last_ch;

    assign sq      = sync_q[NUM_STAGES-1];
    assign sw_acc  = bus.SW_RST && (state_q != S_HOLD);
    assign last_ch = (idx_q == IW'(NUM_CH - 2));

    // synchronizer chain: cleared at once by RST, fills with ones afterwards
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_q <= '0;
        else     sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end

    // sequencer state and registered reset outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    // next state: software reset restarts the stretch, otherwise stretch then release channels in index order
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        done_d  = done_q;
        if (sw_acc) begin
            state_d = S_STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
        end else if (state_q == S_HOLD) begin
            state_d = sq ? S_STRETCH : S_HOLD;
        end else if (state_q == S_STRETCH) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STRETCH - 1)) begin
                cnt_d   = '0;
                rel_d   = NUM_CH'(1);
                done_d  = (NUM_CH == 1);
                state_d = (NUM_CH == 1) ? S_DONE : S_RELEASE;
            end
        end else if (state_q == S_RELEASE) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(REL_DLY - 1)) begin
                cnt_d   = '0;
                idx_d   = idx_q + IW'(1);
                rel_d   = (rel_q << 1) | NUM_CH'(1);
                done_d  = last_ch;
                state_d = last_ch ? S_DONE : S_RELEASE;
            end
        end
    end

`ifdef RST_CAUSE_EN
    logic [1:0] cause_q;

    // last reset source: 01 hardware reset, 10 accepted software reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         cause_q <= 2'b01;
        else if (sw_acc) cause_q <= 2'b10;
    end
`endif

    // outputs come straight from flops
    always_comb begin
        bus.SYNC_RST = rel_q;
        bus.RST_DONE = done_q;
`ifdef RST_CAUSE_EN
        bus.RST_CAUSE = cause_q;
`endif
    end
endmodule
